// File: rtl/dm_pkg.sv
// Shared MEM-stage data memory encodings.
// Used by the DM, the control unit and MEM forwarding.
package dm_pkg;

  typedef enum logic [2:0] {
    DM_WORD  = 3'd0,
    DM_HALF  = 3'd1,
    DM_BYTE  = 3'd2,
    DM_HALFU = 3'd3,
    DM_BYTEU = 3'd4
  } dm_op_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } dm_state_e;

  localparam logic [2:0] DM_OP_MAX = 3'd4;

  function automatic logic op_is_half(
    input logic [2:0] op
  );
    return (op == DM_HALF) || (op == DM_HALFU);
  endfunction

endpackage

// File: rtl/dm_lane_ext.sv
// Byte-lane steering for stores and
// sign/zero extension for loads.
module dm_lane_ext
  import dm_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] wd,
  input  logic [31:0] word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [15:0] half;
  logic [7:0]  byt;

  always_comb begin
    half  = off[1] ? word[31:16] : word[15:0];
    byt   = word[{off, 3'b000} +: 8];
    be    = 4'b0000;
    wdata = wd;
    rdata = '0;
    unique case (op)
      DM_WORD: begin
        be    = 4'b1111;
        rdata = word;
      end
      DM_HALF: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wd[15:0]}};
        rdata = {{16{half[15]}}, half};
      end
      DM_HALFU: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wd[15:0]}};
        rdata = {16'h0, half};
      end
      DM_BYTE: begin
        be    = 4'b0001 << off;
        wdata = {4{wd[7:0]}};
        rdata = {{24{byt[7]}}, byt};
      end
      DM_BYTEU: begin
        be    = 4'b0001 << off;
        wdata = {4{wd[7:0]}};
        rdata = {24'h0, byt};
      end
      default: begin
        be    = 4'b0000;
        wdata = wd;
        rdata = '0;
      end
    endcase
  end

endmodule

// File: rtl/dm_sized_clr.sv
// MEM-stage data memory with byte lanes,
// access checking and a post-reset clear.
module dm_sized_clr
  import dm_pkg::*;
#(
  parameter int          DEPTH_WORDS = 3072,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        DM_write,
  input  logic [2:0]  DMop,
  input  logic [31:0] DM_addr,
  input  logic [31:0] DM_WD,
  output logic [31:0] DMout,
  output logic        DM_ready,
  output logic        DM_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT =
    32'(DEPTH_WORDS * 4);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(DEPTH_WORDS - 1);

  dm_state_e        state, state_nx;
  logic [IDX_W-1:0] clr_ptr;
  logic [31:0]      mem [DEPTH_WORDS];

  logic [31:0]      off;
  logic [IDX_W-1:0] idx;
  logic             idle;
  logic             range_err;
  logic             align_err;
  logic             we_ok;
  logic [31:0]      word;
  logic [3:0]       be;
  logic [31:0]      wdata;
  logic [31:0]      rdata;

  assign off  = DM_addr - BASE_ADDR;
  assign idx  = off[IDX_W+1:2];
  assign idle = (state == ST_IDLE);

  // Unsigned compare also catches addresses below BASE.
  assign range_err = (off >= LIMIT);
  assign align_err =
    ((DMop == DM_WORD) && (off[1:0] != 2'b00)) ||
    (op_is_half(DMop) && off[0]);

  assign DM_err = idle &
    (range_err | align_err | (DMop > DM_OP_MAX));

  assign we_ok    = idle && DM_write && !DM_err;
  assign word     = range_err ? '0 : mem[idx];
  assign DMout    = (idle && !DM_err) ? rdata : '0;
  assign DM_ready = idle;

  dm_lane_ext u_lane (
    .op    (DMop),
    .off   (off[1:0]),
    .wd    (DM_WD),
    .word  (word),
    .be    (be),
    .wdata (wdata),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_CLEAR && clr_ptr != LAST)
        clr_ptr <= clr_ptr + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    if (state == ST_CLEAR && clr_ptr == LAST)
      state_nx = ST_IDLE;
  end

  // Array has no reset; the clear walk zeroes it.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_ptr] <= '0;
    end else if (we_ok) begin
      for (int b = 0; b < 4; b++)
        if (be[b])
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_dm_sized_clr.sv
// Randomized bench for dm_sized_clr against a
// word-array reference model plus directed checks.
module tb_dm_sized_clr;

  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        DM_write = 1'b0;
  logic [2:0]  DMop = 3'd0;
  logic [31:0] DM_addr = 32'h0;
  logic [31:0] DM_WD = 32'h0;
  logic [31:0] DMout;
  logic        DM_ready;
  logic        DM_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mm [D];
  int          cnt = 0;

  always #5 clk = ~clk;

  dm_sized_clr #(
    .DEPTH_WORDS (D),
    .BASE_ADDR   (32'h0)
  ) dut (
    .clk      (clk),
    .reset    (rst),
    .DM_write (DM_write),
    .DMop     (DMop),
    .DM_addr  (DM_addr),
    .DM_WD    (DM_WD),
    .DMout    (DMout),
    .DM_ready (DM_ready),
    .DM_err   (DM_err)
  );

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t",
               nm, got, exp, $time);
    end
  endtask

  function automatic bit m_err(input logic [2:0] op,
                               input logic [31:0] a);
    bit bad;
    bad = (a >= 32'(D * 4)) || (op > 3'd4);
    if (op == 3'd0 && (a % 4) != 0) bad = 1;
    if ((op == 3'd1 || op == 3'd3) && (a % 2) != 0)
      bad = 1;
    return bad;
  endfunction

  function automatic logic [31:0] m_load(
    input logic [2:0] op, input logic [31:0] a);
    logic [31:0] w, h, b;
    w = mm[a / 4];
    h = (w >> (16 * ((a / 2) % 2))) & 32'hffff;
    b = (w >> (8 * (a % 4))) & 32'hff;
    case (op)
      3'd0: return w;
      3'd1: return (h >= 32'h8000) ? (h | 32'hffff0000) : h;
      3'd2: return (b >= 32'h80) ? (b | 32'hffffff00) : b;
      3'd3: return h;
      3'd4: return b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_store(
    input logic [2:0] op, input logic [31:0] a,
    input logic [31:0] w, input logic [31:0] d);
    int sh;
    if (op == 3'd0) return d;
    if (op == 3'd1 || op == 3'd3) begin
      sh = 16 * ((a / 2) % 2);
      return (w & ~(32'hffff << sh)) |
             ((d & 32'hffff) << sh);
    end
    sh = 8 * (a % 4);
    return (w & ~(32'hff << sh)) | ((d & 32'hff) << sh);
  endfunction

  // Whole array reads as zero once the clear completes.
  always @(posedge clk) begin
    if (rst) begin
      cnt = 0;
      for (int i = 0; i < D; i++) mm[i] = 32'h0;
    end else if (cnt < D) begin
      cnt = cnt + 1;
    end else if (DM_write && !m_err(DMop, DM_addr)) begin
      mm[DM_addr / 4] = m_store(DMop, DM_addr,
                                mm[DM_addr / 4], DM_WD);
    end
  end

  always @(negedge clk) begin
    bit rdy, e;
    logic [31:0] o;
    rdy = !rst && (cnt >= D);
    e   = rdy && m_err(DMop, DM_addr);
    o   = (rdy && !e) ? m_load(DMop, DM_addr) : 32'h0;
    chk("m_ready", {31'h0, DM_ready}, {31'h0, rdy});
    chk("m_err", {31'h0, DM_err}, {31'h0, e});
    chk("m_dout", DMout, o);
  end

  task automatic setin(input bit we, input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] d);
    DM_write = we;
    DMop     = op;
    DM_addr  = a;
    DM_WD    = d;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    DM_write = 1'b0;
  endtask

  task automatic st(input logic [2:0] op,
                    input logic [31:0] a,
                    input logic [31:0] d);
    setin(1, op, a, d);
    nxt();
  endtask

  task automatic ld(input string nm,
                    input logic [2:0] op,
                    input logic [31:0] a,
                    input logic [31:0] exp);
    setin(0, op, a, 32'h0);
    @(negedge clk);
    chk(nm, DMout, exp);
    nxt();
  endtask

  task automatic err_at(input string nm, input bit we,
                        input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] d);
    setin(we, op, a, d);
    @(negedge clk);
    chk(nm, {31'h0, DM_err}, 32'h1);
    chk({nm, "_dout"}, DMout, 32'h0);
    nxt();
  endtask

  task automatic clr_seq(input string nm);
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      chk({nm, "_lo"}, {31'h0, DM_ready}, 32'h0);
    end
    @(negedge clk);
    chk({nm, "_hi"}, {31'h0, DM_ready}, 32'h1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (DM_ready) break;
    end
    chk("ready_timeout", {31'h0, DM_ready}, 32'h1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    setin(0, 3'd0, 32'h0, 32'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clr_seq("clear1");
    for (int a = 0; a <= 60; a += 4)
      ld("clear_lw", 3'd0, 32'(a), 32'h0);

    st(3'd0, 32'h0, 32'habcd5555);
    st(3'd0, 32'h4, 32'hab005511);
    st(3'd2, 32'h0, 32'h000000fe);
    ld("lw0", 3'd0, 32'h0, 32'habcd55fe);
    ld("lw4", 3'd0, 32'h4, 32'hab005511);
    ld("lb0", 3'd2, 32'h0, 32'hfffffffe);
    ld("lbu0", 3'd4, 32'h0, 32'h000000fe);
    st(3'd1, 32'h6, 32'h00008001);
    ld("lh6", 3'd1, 32'h6, 32'hffff8001);
    ld("lhu6", 3'd3, 32'h6, 32'h00008001);
    ld("lw4b", 3'd0, 32'h4, 32'h80015511);

    err_at("sw2_err", 1, 3'd0, 32'h2, 32'h12345678);
    ld("lw0_keep", 3'd0, 32'h0, 32'habcd55fe);
    err_at("lh3_err", 0, 3'd1, 32'h3, 32'h0);
    err_at("sw64_err", 1, 3'd0, 32'd64, 32'h1);
    ld("lw0_keep2", 3'd0, 32'h0, 32'habcd55fe);
    err_at("op6_err", 0, 3'd6, 32'h0, 32'h0);

    st(3'd0, 32'h8, 32'hcafef00d);
    ld("lw8_pre", 3'd0, 32'h8, 32'hcafef00d);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    st(3'd0, 32'h8, 32'hdeadbeef);
    wait_ready();
    ld("lw8_clr", 3'd0, 32'h8, 32'h0);

    st(3'd0, 32'h4, 32'h5a5a5a5a);
    ld("lw4_pre", 3'd0, 32'h4, 32'h5a5a5a5a);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr_seq("clear2");
    ld("lw4_clr", 3'd0, 32'h4, 32'h0);

    st(3'd0, 32'h0, 32'h11111111);
    setin(1, 3'd0, 32'h0, 32'h22222222);
    @(negedge clk);
    chk("rdw_old", DMout, 32'h11111111);
    nxt();
    setin(0, 3'd0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rdw_new", DMout, 32'h22222222);
    @(posedge clk);
    #1;

    for (int i = 0; i < 1500; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      op = ($urandom_range(0, 9) == 0) ?
           3'($urandom_range(5, 7)) :
           3'($urandom_range(0, 4));
      a  = ($urandom_range(0, 15) == 0) ?
           $urandom : 32'($urandom_range(0, 70));
      if (i == 700) begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
      end
      setin(1'($urandom_range(0, 1)), op, a, $urandom);
      @(posedge clk);
      #1;
    end
    setin(0, 3'd0, 32'h0, 32'h0);
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
